// File: rtl/gon_tag_issuer_if.sv
// rtl/gon_tag_issuer_if.sv - GON tagged-multicast bus interface
//
// Purpose: one transmit lane of the GON bus. The issuer drives a tag and a
// data beat with a valid; the matching PE-side controllers answer with a
// single ready that has already been OR-ed together.
//
// Signals:
//   tag        issuer -> PEs   destination tag, held for a whole command
//   data       issuer -> PEs   data beat
//   valid_out  issuer -> PEs   beat valid
//   ready_in   PEs -> issuer   OR of ready from all matching controllers
interface gon_tag_issuer_if #(
   parameter int ID_SIZE   = 8,
   parameter int DATA_SIZE = 64
);
   logic [ID_SIZE-1:0]   tag;
   logic [DATA_SIZE-1:0] data;
   logic                 valid_out;
   logic                 ready_in;

   modport master (output tag, output data, output valid_out, input ready_in);
   modport slave  (input tag, input data, input valid_out, output ready_in);
endinterface

// File: rtl/gon_tag_issuer.sv
// rtl/gon_tag_issuer.sv - GON bus transmit side: tagged command to beat stream
//
// Purpose: accepts a command (destination tag + beat count), then pulls that
// many beats from the global-buffer read path and streams them onto the GON
// bus with the tag held constant. A one-cycle done pulse marks completion.
//
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset
//   cmd_valid_i  command offered
//   cmd_ready_o  command accepted when cmd_valid_i & cmd_ready_o
//   cmd_tag_i    destination tag for the command
//   cmd_len_i    number of beats; 0 = empty command
//   din_valid_i  source beat valid
//   din_ready_o  source beat accepted when din_valid_i & din_ready_o
//   din_i        source beat
//   bus          GON bus (tag, data, valid_out out; ready_in in)
//   done_o       one-cycle pulse when the command completes
module gon_tag_issuer #(
   parameter int ID_SIZE   = 8,
   parameter int DATA_SIZE = 64,
   parameter int LEN_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_valid_i,
   output logic                 cmd_ready_o,
   input  logic [ID_SIZE-1:0]   cmd_tag_i,
   input  logic [LEN_W-1:0]     cmd_len_i,
   input  logic                 din_valid_i,
   output logic                 din_ready_o,
   input  logic [DATA_SIZE-1:0] din_i,
   gon_tag_issuer_if.master     bus,
   output logic                 done_o
);

   typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;

   state_e               state_q, state_d;
   logic [ID_SIZE-1:0]   tag_q, tag_d;
   logic [DATA_SIZE-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic [LEN_W-1:0]     len_q, len_d;
   // issued counts beats pulled from the source, sent counts beats the bus
   // accepted; both are LEN_W wide so the maximum length cannot wrap.
   logic [LEN_W-1:0]     issued_q, issued_d;
   logic [LEN_W-1:0]     sent_q, sent_d;
   logic                 din_hs;
   logic                 fire;

   assign bus.tag       = tag_q;
   assign bus.data      = data_q;
   assign bus.valid_out = valid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         tag_q    <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         len_q    <= '0;
         issued_q <= '0;
         sent_q   <= '0;
      end else begin
         state_q  <= state_d;
         tag_q    <= tag_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         len_q    <= len_d;
         issued_q <= issued_d;
         sent_q   <= sent_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      tag_d       = tag_q;
      data_d      = data_q;
      valid_d     = valid_q;
      len_d       = len_q;
      issued_d    = issued_q;
      sent_d      = sent_q;
      cmd_ready_o = 1'b0;
      din_ready_o = 1'b0;
      done_o      = 1'b0;
      din_hs      = 1'b0;
      fire        = 1'b0;

      case (state_q)
         IDLE: begin
            cmd_ready_o = 1'b1;
            if (cmd_valid_i) begin
               tag_d    = cmd_tag_i;
               len_d    = cmd_len_i;
               issued_d = '0;
               sent_d   = '0;
               state_d  = (cmd_len_i == '0) ? DONE : SEND;
            end
         end

         SEND: begin
            // The single output register may be refilled in the same cycle
            // it drains, which is what gives one beat per cycle.
            din_ready_o = (issued_q < len_q) && (!valid_q || bus.ready_in);
            din_hs      = din_ready_o && din_valid_i;
            fire        = valid_q && bus.ready_in;

            if (fire) begin
               sent_d  = sent_q + 1'b1;
               valid_d = 1'b0;
               if (sent_q == len_q - 1'b1) begin
                  state_d = DONE;
               end
            end
            // A load in the same cycle as a fire overrides the drain above.
            if (din_hs) begin
               data_d   = din_i;
               valid_d  = 1'b1;
               issued_d = issued_q + 1'b1;
            end
         end

         DONE: begin
            done_o  = 1'b1;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_gon_tag_issuer.sv
// tb/tb_gon_tag_issuer.sv - self-checking bench for gon_tag_issuer
module tb_gon_tag_issuer;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic [7:0]  cmd_tag_i;
   logic [7:0]  cmd_len_i;
   logic        din_valid_i;
   logic        din_ready_o;
   logic [63:0] din_i;
   logic        done_o;

   gon_tag_issuer_if #(.ID_SIZE(8), .DATA_SIZE(64)) bus ();

   gon_tag_issuer #(.ID_SIZE(8), .DATA_SIZE(64), .LEN_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid_i (cmd_valid_i),
      .cmd_ready_o (cmd_ready_o),
      .cmd_tag_i   (cmd_tag_i),
      .cmd_len_i   (cmd_len_i),
      .din_valid_i (din_valid_i),
      .din_ready_o (din_ready_o),
      .din_i       (din_i),
      .bus         (bus),
      .done_o      (done_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  tag;
      logic [63:0] data;
   } beat_t;

   typedef struct {
      int tag;
      int len;
      int stall;
      int exp_done;
   } vec_t;

   int errors = 0;
   int checks = 0;

   // Transaction-level reference: every accepted source beat is owed to the
   // bus, in order, under the tag of the command that was open when it was taken.
   beat_t       expq[$];
   logic [7:0]  cur_tag;
   int          cur_len;
   int          accepted;
   int          din_total;
   int          fire_total;
   int          done_total;
   bit          hold_prev;
   logic [7:0]  prev_tag;
   logic [63:0] prev_data;
   bit          din_hs_prev;
   bit          cmd_hs_now;
   bit          din_hs_now;
   bit          done_now;

   task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      expq.delete();
      accepted    = 0;
      cur_len     = 0;
      hold_prev   = 1'b0;
      din_hs_prev = 1'b0;
   endtask

   task automatic monitor();
      beat_t b;
      cmd_hs_now = 1'b0;
      din_hs_now = 1'b0;
      done_now   = 1'b0;
      if (!rst_n) return;
      if (hold_prev) begin
         check(bus.valid_out === 1'b1, "stall_valid_held", bus.valid_out, 1);
         check(bus.tag === prev_tag && bus.data === prev_data, "stall_beat_stable", bus.data, prev_data);
      end
      if (din_hs_prev)
         check(bus.valid_out === 1'b1, "din_to_valid_latency", bus.valid_out, 1);
      if (cmd_valid_i && cmd_ready_o) begin
         cmd_hs_now = 1'b1;
         cur_tag    = cmd_tag_i;
         cur_len    = int'(cmd_len_i);
         accepted   = 0;
      end
      if (din_valid_i && din_ready_o) begin
         din_hs_now = 1'b1;
         check(accepted < cur_len, "over_issue", accepted, cur_len);
         accepted++;
         din_total++;
         b.tag  = cur_tag;
         b.data = din_i;
         expq.push_back(b);
      end
      if (bus.valid_out && bus.ready_in) begin
         fire_total++;
         if (expq.size() == 0) begin
            check(1'b0, "spurious_beat", bus.data, 0);
         end else begin
            b = expq.pop_front();
            check(bus.tag === b.tag, "beat_tag", bus.tag, b.tag);
            check(bus.data === b.data, "beat_data", bus.data, b.data);
         end
      end
      if (done_o) begin
         done_now = 1'b1;
         done_total++;
         check(expq.size() == 0 && accepted == cur_len, "done_all_beats_out", accepted, cur_len);
         check(!din_ready_o && !cmd_ready_o && !bus.valid_out, "done_outputs",
               {din_ready_o, cmd_ready_o, bus.valid_out}, 0);
      end
      hold_prev   = bus.valid_out && !bus.ready_in;
      prev_tag    = bus.tag;
      prev_data   = bus.data;
      din_hs_prev = din_hs_now;
   endtask

   // One clock: observe at the falling edge, then change the source word
   // just after the rising edge if it was consumed.
   task automatic step();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      if (din_hs_now) din_i = din_i + 64'd1;
   endtask

   task automatic check_reset_vals(input string pfx);
      check(bus.tag === 8'h0, {pfx, "_tag"}, bus.tag, 0);
      check(bus.data === 64'h0, {pfx, "_data"}, bus.data, 0);
      check(bus.valid_out === 1'b0, {pfx, "_valid"}, bus.valid_out, 0);
      check(done_o === 1'b0, {pfx, "_done"}, done_o, 0);
      check(cmd_ready_o === 1'b1, {pfx, "_cmd_ready"}, cmd_ready_o, 1);
      check(din_ready_o === 1'b0, {pfx, "_din_ready"}, din_ready_o, 0);
   endtask

   task automatic run_cmd(input int tag, input int len, input int stall, input bit rnd, output int done_cyc);
      bit got_hs;
      int d0;
      int f0;
      cmd_tag_i   = 8'(tag);
      cmd_len_i   = 8'(len);
      cmd_valid_i = 1'b1;
      din_valid_i = 1'b1;
      bus.ready_in = 1'b1;
      got_hs = 1'b0;
      for (int w = 0; w < 20 && !got_hs; w++) begin
         step();
         got_hs = cmd_hs_now;
      end
      cmd_valid_i = 1'b0;
      check(got_hs, "cmd_handshake", got_hs, 1);
      d0 = din_total - (din_hs_now ? 1 : 0);
      f0 = fire_total;
      done_cyc = -1;
      for (int k = 1; k < len + stall + 600 && done_cyc < 0; k++) begin
         if (rnd) begin
            din_valid_i  = ($urandom_range(0, 3) != 0);
            bus.ready_in = ($urandom_range(0, 3) != 0);
         end else begin
            bus.ready_in = !(k >= 2 && k < 2 + stall);
         end
         step();
         if (done_now) done_cyc = k;
      end
      check(done_cyc >= 0, "done_timeout", done_cyc, 0);
      check(fire_total - f0 == len, "beats_fired", fire_total - f0, len);
      check(din_total - d0 == len, "din_consumed", din_total - d0, len);
      din_valid_i  = 1'b1;
      bus.ready_in = 1'b1;
      step();
      check(cmd_ready_o === 1'b1, "cmd_ready_after_done", cmd_ready_o, 1);
   endtask

   vec_t vecs[6];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int dc;
      int gap;
      int d0;
      bit got;

      vecs[0] = '{tag: 5, len: 4,   stall: 0, exp_done: 6};
      vecs[1] = '{tag: 3, len: 3,   stall: 5, exp_done: 10};
      vecs[2] = '{tag: 2, len: 0,   stall: 0, exp_done: 1};
      vecs[3] = '{tag: 9, len: 1,   stall: 0, exp_done: 3};
      vecs[4] = '{tag: 6, len: 2,   stall: 0, exp_done: 4};
      vecs[5] = '{tag: 4, len: 255, stall: 0, exp_done: 257};

      rst_n        = 1'b0;
      cmd_valid_i  = 1'b0;
      cmd_tag_i    = 8'h0;
      cmd_len_i    = 8'h0;
      din_valid_i  = 1'b0;
      din_i        = 64'hA0;
      bus.ready_in = 1'b0;
      din_total    = 0;
      fire_total   = 0;
      done_total   = 0;
      cur_tag      = 8'h0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals("reset");
      rst_n = 1'b1;
      step();

      // Directed table: throughput, stall, empty, single, over-offer, max length.
      for (int i = 0; i < 6; i++) begin
         if (i == 0) din_i = 64'hA0;
         run_cmd(vecs[i].tag, vecs[i].len, vecs[i].stall, 1'b0, dc);
         check(dc == vecs[i].exp_done, "done_latency", dc, vecs[i].exp_done);
      end

      // Second command waits in front of a busy issuer.
      cmd_tag_i   = 8'd1;
      cmd_len_i   = 8'd2;
      cmd_valid_i = 1'b1;
      din_valid_i = 1'b1;
      bus.ready_in = 1'b1;
      got = 1'b0;
      for (int w = 0; w < 20 && !got; w++) begin
         step();
         got = cmd_hs_now;
      end
      check(got, "queued_first_hs", got, 1);
      d0 = done_total;
      cmd_tag_i = 8'd7;
      cmd_len_i = 8'd1;
      got = 1'b0;
      gap = 0;
      for (int w = 0; w < 20 && !got; w++) begin
         step();
         gap++;
         got = cmd_hs_now;
      end
      cmd_valid_i = 1'b0;
      check(gap == 5, "queued_gap", gap, 5);
      check(done_total == d0 + 1, "queued_done_between", done_total, d0 + 1);
      got = 1'b0;
      for (int w = 0; w < 20 && !got; w++) begin
         step();
         got = done_now;
      end
      check(got, "queued_second_done", got, 1);
      step();

      // Reset while the second of three beats is stalled on the bus.
      cmd_tag_i   = 8'd3;
      cmd_len_i   = 8'd3;
      cmd_valid_i = 1'b1;
      got = 1'b0;
      for (int w = 0; w < 20 && !got; w++) begin
         step();
         got = cmd_hs_now;
      end
      cmd_valid_i = 1'b0;
      step();
      step();
      bus.ready_in = 1'b0;
      #1;
      check(bus.valid_out === 1'b1, "pre_reset_valid", bus.valid_out, 1);
      rst_n = 1'b0;
      #1;
      check_reset_vals("midreset");
      model_reset();
      d0 = done_total;
      step();
      step();
      rst_n = 1'b1;
      bus.ready_in = 1'b1;
      repeat (3) step();
      check(done_total == d0, "no_done_after_reset", done_total, d0);
      run_cmd(12, 3, 0, 1'b0, dc);
      check(dc == 5, "post_reset_latency", dc, 5);

      // Random traffic against the reference scoreboard.
      din_i = {$urandom, $urandom};
      for (int i = 0; i < 30; i++) begin
         run_cmd(int'($urandom_range(0, 255)), int'($urandom_range(0, 12)), 0, 1'b1, dc);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
